// File: rtl/poro_draw_sequencer_if.sv
// Plot/done handshake and object-table write bus between game logic, the draw
// sequencer and the 16x16 sprite graphing unit.
interface poro_draw_sequencer_if #(
  parameter int IDX_W = 3
) ();
  logic             frame_tick;
  logic             obj_we;
  logic [IDX_W-1:0] obj_idx;
  logic [8:0]       obj_x;
  logic [7:0]       obj_y;
  logic             obj_valid;
  logic             plot;
  logic [8:0]       x_out;
  logic [7:0]       y_out;
  logic             done;
  logic             busy;
  logic             frame_done;
  logic [IDX_W:0]   n_skipped;
  logic             err_timeout;
  logic             err_overrun;

  // Sequencer side: initiates plots, consumes table writes and done.
  modport master (
    input  frame_tick, obj_we, obj_idx, obj_x, obj_y, obj_valid, done,
    output plot, x_out, y_out, busy, frame_done, n_skipped,
    output err_timeout, err_overrun
  );

  // Environment side: game logic plus graphing unit.
  modport slave (
    output frame_tick, obj_we, obj_idx, obj_x, obj_y, obj_valid, done,
    input  plot, x_out, y_out, busy, frame_done, n_skipped,
    input  err_timeout, err_overrun
  );
endinterface

// File: rtl/poro_draw_sequencer.sv
// Draw sequencer: holds an object position table and, on each frame_tick,
// walks it in index order issuing one plot per valid on-screen sprite, waiting
// for the graphing unit's done (bounded by a timeout) between plots.
module poro_draw_sequencer #(
  parameter int N_OBJ   = 8,
  parameter int IDX_W   = 3,
  parameter int SPR     = 16,
  parameter int SCR_W   = 320,
  parameter int SCR_H   = 240,
  parameter int TIMEOUT = 1023
) (
  input logic                   clk,
  input logic                   resetn,
  poro_draw_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_GAP, S_FDONE
  } state_t;

  localparam logic [9:0]       CLIP_X   = 10'(SCR_W - SPR);
  localparam logic [9:0]       CLIP_Y   = 10'(SCR_H - SPR);
  localparam logic [9:0]       TMO      = 10'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  // Object table
  logic [N_OBJ-1:0] valid_q;
  logic [8:0]       xs_q [N_OBJ];
  logic [7:0]       ys_q [N_OBJ];

  // Walk state and registered outputs
  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   skip_q;
  logic [9:0]       timer_q;
  logic             plot_q;
  logic [8:0]       x_q;
  logic [7:0]       y_q;
  logic             busy_q;
  logic             frame_done_q;
  logic [IDX_W:0]   n_skipped_q;
  logic             err_timeout_q;
  logic             err_overrun_q;

  logic             cur_valid;
  logic [8:0]       cur_x;
  logic [7:0]       cur_y;
  logic             cur_clipped;
  logic             idx_last;

  // A sprite is clipped when any part would fall past the right/bottom edge;
  // widened to 10 bits so the comparison cannot wrap.
  function automatic logic is_clipped(input logic [8:0] px, input logic [7:0] py);
    return ({1'b0, px} > CLIP_X) || ({2'b00, py} > CLIP_Y);
  endfunction

  // Valid bits are the only table state that needs clearing on reset.
  always_ff @(posedge clk) begin
    if (!resetn)
      valid_q <= '0;
    else if (bus.obj_we)
      valid_q[bus.obj_idx] <= bus.obj_valid;
  end

  // Position payload, written whenever the game logic strobes an entry.
  always_ff @(posedge clk) begin
    if (bus.obj_we) begin
      xs_q[bus.obj_idx] <= bus.obj_x;
      ys_q[bus.obj_idx] <= bus.obj_y;
    end
  end

  // Live read of the entry under the scan pointer.
  always_comb begin
    cur_valid   = valid_q[idx_q];
    cur_x       = xs_q[idx_q];
    cur_y       = ys_q[idx_q];
    cur_clipped = is_clipped(cur_x, cur_y);
    idx_last    = (idx_q == LAST_IDX);
  end

  // Frame walk FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      skip_q        <= '0;
      timer_q       <= '0;
      plot_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      n_skipped_q   <= '0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      plot_q       <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.frame_tick && state_q != S_IDLE)
        err_overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (bus.frame_tick) begin
            state_q <= S_SCAN;
            idx_q   <= '0;
            skip_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_SCAN: begin
          if (cur_valid && !cur_clipped) begin
            state_q <= S_ISSUE;
            plot_q  <= 1'b1;
            x_q     <= cur_x;
            y_q     <= cur_y;
          end else begin
            if (cur_valid)
              skip_q <= skip_q + (IDX_W+1)'(1);
            state_q      <= idx_last ? S_FDONE : S_SCAN;
            frame_done_q <= idx_last;
            idx_q        <= idx_q + IDX_W'(1);
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over a timeout landing on the same cycle
          if (bus.done) begin
            state_q <= S_GAP;
          end else if (timer_q == TMO) begin
            err_timeout_q <= 1'b1;
            state_q       <= idx_last ? S_FDONE : S_SCAN;
            frame_done_q  <= idx_last;
            idx_q         <= idx_q + IDX_W'(1);
          end else begin
            timer_q <= timer_q + 10'd1;
          end
        end
        S_GAP: begin
          // plotter needs one idle cycle to return to its load state
          state_q      <= idx_last ? S_FDONE : S_SCAN;
          frame_done_q <= idx_last;
          idx_q        <= idx_q + IDX_W'(1);
        end
        S_FDONE: begin
          n_skipped_q <= skip_q;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.plot        = plot_q;
  assign bus.x_out       = x_q;
  assign bus.y_out       = y_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.n_skipped   = n_skipped_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_poro_draw_sequencer.sv
// Directed bench for poro_draw_sequencer with a delayed-done plotter model.
module tb_poro_draw_sequencer;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  poro_draw_sequencer_if #(.IDX_W(3)) ifc ();

  poro_draw_sequencer #(
    .N_OBJ(8), .IDX_W(3), .SPR(16), .SCR_W(320), .SCR_H(240), .TIMEOUT(1023)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int plot_cnt = 0;
  int fd_cnt = 0;
  int gap_viol = 0;
  int last_done_cyc = -100;
  int px [16];
  int py [16];
  bit done_en = 1'b1;
  int done_delay = 520;
  int dcnt = 0;

  // Plotter model and output monitor, both on the falling edge.
  always @(negedge clk) begin
    if (ifc.plot) begin
      if (plot_cnt < 16) begin
        px[plot_cnt] = int'(ifc.x_out);
        py[plot_cnt] = int'(ifc.y_out);
      end
      plot_cnt++;
      if (cyc - last_done_cyc <= 2) gap_viol++;
    end
    if (ifc.frame_done) fd_cnt++;
    ifc.done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        ifc.done = 1'b1;
        last_done_cyc = cyc;
      end
    end
    if (ifc.plot && done_en) dcnt = done_delay;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(int idx, int x, int y, bit v);
    ifc.obj_we    = 1'b1;
    ifc.obj_idx   = idx[2:0];
    ifc.obj_x     = x[8:0];
    ifc.obj_y     = y[7:0];
    ifc.obj_valid = v;
    step();
    ifc.obj_we    = 1'b0;
  endtask

  task automatic tick();
    ifc.frame_tick = 1'b1;
    step();
    ifc.frame_tick = 1'b0;
  endtask

  task automatic clear_mon();
    plot_cnt = 0;
    fd_cnt   = 0;
    gap_viol = 0;
  endtask

  task automatic wait_frame(int budget, string tag);
    int start = fd_cnt;
    int n = 0;
    while (fd_cnt == start && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(fd_cnt != start), 32'd1);
    n = 0;
    while (ifc.busy && n < 10) begin
      step();
      n++;
    end
  endtask

  task automatic wait_plots(int want, int budget, string tag);
    int n = 0;
    while (plot_cnt < want && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(plot_cnt >= want), 32'd1);
  endtask

  initial begin
    ifc.frame_tick = 1'b0;
    ifc.obj_we     = 1'b0;
    ifc.obj_idx    = '0;
    ifc.obj_x      = '0;
    ifc.obj_y      = '0;
    ifc.obj_valid  = 1'b0;
    ifc.done       = 1'b0;

    // Reset state
    step(3);
    check("rst_plot", 32'(ifc.plot), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_x", 32'(ifc.x_out), 32'd0);
    check("rst_fdone", 32'(ifc.frame_done), 32'd0);
    check("rst_nskip", 32'(ifc.n_skipped), 32'd0);
    check("rst_etmo", 32'(ifc.err_timeout), 32'd0);
    resetn = 1'b1;
    step();

    // Two valid objects, plotter answers 520 cycles after each plot
    wr(0, 10, 20, 1'b1);
    wr(3, 100, 50, 1'b1);
    clear_mon();
    tick();
    check("t1_busy", 32'(ifc.busy), 32'd1);
    wait_frame(3000, "t1_frame");
    check("t1_nplot", 32'(plot_cnt), 32'd2);
    check("t1_x0", 32'(px[0]), 32'd10);
    check("t1_y0", 32'(py[0]), 32'd20);
    check("t1_x1", 32'(px[1]), 32'd100);
    check("t1_y1", 32'(py[1]), 32'd50);
    check("t1_nfd", 32'(fd_cnt), 32'd1);
    check("t1_nskip", 32'(ifc.n_skipped), 32'd0);
    check("t1_busy_end", 32'(ifc.busy), 32'd0);
    check("t1_etmo", 32'(ifc.err_timeout), 32'd0);
    check("t1_eovr", 32'(ifc.err_overrun), 32'd0);

    // Clipping boundaries, plus a second frame_tick mid-walk
    wr(0, 10, 20, 1'b0);
    wr(3, 100, 50, 1'b0);
    wr(1, 305, 0, 1'b1);
    wr(2, 0, 225, 1'b1);
    wr(4, 304, 224, 1'b1);
    clear_mon();
    tick();
    step(6);
    tick();
    check("t4_eovr", 32'(ifc.err_overrun), 32'd1);
    wait_frame(3000, "t2_frame");
    check("t2_nplot", 32'(plot_cnt), 32'd1);
    check("t2_x", 32'(px[0]), 32'd304);
    check("t2_y", 32'(py[0]), 32'd224);
    check("t2_nskip", 32'(ifc.n_skipped), 32'd2);
    step(600);
    check("t4_nfd", 32'(fd_cnt), 32'd1);
    check("t4_nplot", 32'(plot_cnt), 32'd1);
    check("t4_busy", 32'(ifc.busy), 32'd0);

    // Plotter never answers: timeout then continue with the next object
    wr(5, 50, 60, 1'b1);
    done_en = 1'b0;
    clear_mon();
    tick();
    wait_plots(1, 100, "t3_first_plot");
    step(1000);
    check("t3_etmo_early", 32'(ifc.err_timeout), 32'd0);
    step(30);
    check("t3_etmo", 32'(ifc.err_timeout), 32'd1);
    wait_frame(3000, "t3_frame");
    check("t3_nplot", 32'(plot_cnt), 32'd2);
    check("t3_x1", 32'(px[1]), 32'd50);
    check("t3_y1", 32'(py[1]), 32'd60);
    check("t3_nfd", 32'(fd_cnt), 32'd1);
    check("t3_nskip", 32'(ifc.n_skipped), 32'd2);

    // Reset during WAIT
    done_en = 1'b1;
    done_delay = 520;
    clear_mon();
    tick();
    wait_plots(1, 100, "t5_plot");
    step(10);
    resetn = 1'b0;
    step();
    dcnt = 0;
    check("t5_plot", 32'(ifc.plot), 32'd0);
    check("t5_busy", 32'(ifc.busy), 32'd0);
    check("t5_x", 32'(ifc.x_out), 32'd0);
    check("t5_etmo", 32'(ifc.err_timeout), 32'd0);
    check("t5_eovr", 32'(ifc.err_overrun), 32'd0);
    resetn = 1'b1;
    step();
    clear_mon();
    tick();
    wait_frame(100, "t5_frame");
    check("t5_nplot", 32'(plot_cnt), 32'd0);
    check("t5_nfd", 32'(fd_cnt), 32'd1);

    // Late write to an unscanned entry is used in the same frame
    done_delay = 20;
    wr(0, 10, 20, 1'b1);
    wr(1, 20, 30, 1'b1);
    wr(2, 30, 40, 1'b1);
    clear_mon();
    tick();
    wait_plots(3, 500, "t6_third_plot");
    step(5);
    wr(7, 200, 100, 1'b1);
    wait_frame(1000, "t6_frame");
    check("t6_nplot", 32'(plot_cnt), 32'd4);
    check("t6_x2", 32'(px[2]), 32'd30);
    check("t6_x3", 32'(px[3]), 32'd200);
    check("t6_y3", 32'(py[3]), 32'd100);
    check("t6_gap", 32'(gap_viol), 32'd0);
    check("t6_nfd", 32'(fd_cnt), 32'd1);
    check("t6_nskip", 32'(ifc.n_skipped), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
